// File: rtl/l2_neuron_feeder.sv
// Stream front-end for the pipelined neuron: packs samples into an N-lane vector,
// holds the weight/bias bank, tracks issued vectors through the neuron latency and buffers results.
module l2_neuron_feeder #(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int LAT       = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_data,
  input  logic                      cfg_we,
  input  logic [$clog2(N+1)-1:0]    cfg_addr,
  input  logic [WIDTH-1:0]          cfg_wdata,
  output logic                      cfg_err,
  output logic [N*WIDTH-1:0]        nx_x,
  output logic [N*WIDTH-1:0]        nx_w,
  output logic [WIDTH-1:0]          nx_b,
  input  logic [WIDTH-1:0]          nx_y,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH-1:0]          m_data,
  output logic                      busy
);

  localparam int AW = $clog2(N + 1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int KW = PW + 2;

  typedef enum logic {ST_FILL, ST_ISSUE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_elem_cnt;
  logic [WIDTH-1:0] r_x [N];
  logic [WIDTH-1:0] r_w [N];
  logic [WIDTH-1:0] r_b;
  logic [LAT-1:0]   r_tok;
  logic [WIDTH-1:0] r_mem [OUT_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_fifo_cnt;
  logic             r_cfg_err;

  logic             w_accept;
  logic             w_last;
  logic             w_issue;
  logic             w_credit;
  logic             w_push;
  logic             w_pop;
  logic             w_cfg_hit;
  logic             w_cfg_ok;
  logic [KW-1:0]    w_inflight;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FILL:  if (w_accept && w_last) w_next_state = ST_ISSUE;
      ST_ISSUE: if (w_credit)           w_next_state = ST_FILL;
      default:                          w_next_state = ST_FILL;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      ST_FILL:  s_ready = !rst;
      ST_ISSUE: w_issue = w_credit;
      default:  s_ready = 1'b0;
    endcase
  end

  assign w_accept = s_valid && s_ready;
  assign w_last   = (r_elem_cnt == CW'(N - 1));

  // Credit counts results already buffered plus those still inside the neuron.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + KW'(r_tok[i]);
  end

  assign w_credit = (KW'(r_fifo_cnt) + w_inflight) < KW'(OUT_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_elem_cnt <= '0;
      for (int k = 0; k < N; k++) r_x[k] <= '0;
    end else if (w_accept) begin
      r_elem_cnt <= w_last ? '0 : r_elem_cnt + 1'b1;
      for (int k = 0; k < N; k++)
        if (r_elem_cnt == CW'(k)) r_x[k] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tok <= '0;
    end else begin
      r_tok[0] <= w_issue;
      for (int i = 1; i < LAT; i++) r_tok[i] <= r_tok[i-1];
    end
  end

  assign w_push  = r_tok[LAT-1];
  assign w_pop   = m_valid && m_ready;
  assign m_valid = (r_fifo_cnt != '0);
  assign m_data  = r_mem[r_rd_ptr];

  // NOTE: FIFO storage is not reset; only pointers and count are, and they gate visibility of stale data.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= nx_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign busy = (r_state == ST_ISSUE) || (r_elem_cnt != '0) || (|r_tok) || (r_fifo_cnt != '0);

  assign w_cfg_hit = cfg_we && (cfg_addr <= AW'(N));
  assign w_cfg_ok  = w_cfg_hit && !busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b       <= '0;
      r_cfg_err <= 1'b0;
      for (int k = 0; k < N; k++) r_w[k] <= '0;
    end else begin
      r_cfg_err <= w_cfg_hit && busy;
      if (w_cfg_ok) begin
        if (cfg_addr == AW'(N)) r_b <= cfg_wdata;
        for (int k = 0; k < N; k++)
          if (cfg_addr == AW'(k)) r_w[k] <= cfg_wdata;
      end
    end
  end

  assign cfg_err = r_cfg_err;
  assign nx_b    = r_b;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign nx_x[g*WIDTH +: WIDTH] = r_x[g];
    assign nx_w[g*WIDTH +: WIDTH] = r_w[g];
  end

endmodule

// File: tb/tb_l2_neuron_feeder.sv
// Directed bench for l2_neuron_feeder with a behavioural 2-stage ReLU neuron
// (saturating sum of x*w plus b, registered twice) closing the loop on nx_y.
module tb_l2_neuron_feeder;

  localparam int N  = 4;
  localparam int AW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [15:0]   s_data = '0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [15:0]   cfg_wdata = '0;
  logic          cfg_err;
  logic [63:0]   nx_x;
  logic [63:0]   nx_w;
  logic [15:0]   nx_b;
  logic [15:0]   nx_y;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [15:0]   m_data;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_neuron_feeder #(.N(4), .WIDTH(16), .LAT(2), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .nx_x(nx_x), .nx_w(nx_w), .nx_b(nx_b), .nx_y(nx_y),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  function automatic logic [15:0] neuron_sum(input logic [63:0] x, input logic [63:0] w,
                                             input logic [15:0] b);
    longint acc;
    acc = longint'($signed(b));
    for (int k = 0; k < 4; k++)
      acc += longint'($signed(x[k*16 +: 16])) * longint'($signed(w[k*16 +: 16]));
    if (acc > 32767)       acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  logic [15:0] nn_s1 = '0;
  logic [15:0] nn_y  = '0;
  always @(posedge clk) begin
    nn_s1 <= neuron_sum(nx_x, nx_w, nx_b);
    nn_y  <= $signed(nn_s1) < 0 ? 16'h0000 : nn_s1;
  end
  assign nx_y = nn_y;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_sample(input logic [15:0] d);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("s_ready timeout", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Returns at the negedge after the 4th accept; acc_cyc is that accept edge number.
  task automatic send_vec(input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] a3, output int acc_cyc);
    send_sample(a0);
    send_sample(a1);
    send_sample(a2);
    send_sample(a3);
    acc_cyc = cyc;
  endtask

  task automatic cfg_write(input int addr, input logic [15:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_wb(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                        input logic [15:0] w3, input logic [15:0] b);
    cfg_write(0, w0);
    cfg_write(1, w1);
    cfg_write(2, w2);
    cfg_write(3, w3);
    cfg_write(4, b);
  endtask

  task automatic wait_result(input string tag, output logic [15:0] d);
    int n = 0;
    while (!m_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check({tag, " m_valid timeout"}, m_valid, 1);
    d = m_data;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, busy, 0);
  endtask

  int          acc_cyc;
  int          got;
  int          n;
  int          extra;
  int          stamp [6];
  logic [15:0] res;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst s_ready", s_ready, 0);
    check("rst m_valid", m_valid, 0);
    check("rst cfg_err", cfg_err, 0);
    check("rst busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst s_ready", s_ready, 1);
    check("post-rst nx_w", nx_w, 64'h0);

    // 1: unit weights, timing from 4th accept: issue at +1, push at +3
    m_ready = 1'b1;
    set_wb(16'd1, 16'd1, 16'd1, 16'd1, 16'd0);
    check("t1 nx_w", nx_w, 64'h0001_0001_0001_0001);
    check("t1 nx_b", nx_b, 16'd0);
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, acc_cyc);
    check("t1 ISSUE s_ready", s_ready, 0);
    check("t1 ISSUE busy", busy, 1);
    check("t1 nx_x", nx_x, 64'h0004_0003_0002_0001);
    @(negedge clk);
    check("t1 m_valid +1", m_valid, 0);
    check("t1 s_ready back", s_ready, 1);
    @(negedge clk);
    check("t1 m_valid +2", m_valid, 0);
    @(negedge clk);
    check("t1 m_valid +3", m_valid, 1);
    check("t1 m_data", m_data, 16'd10);
    check("t1 latency", cyc - acc_cyc, 3);
    @(negedge clk);
    check("t1 popped", m_valid, 0);
    check("t1 busy end", busy, 0);

    // 2: ReLU clamp and negative inputs
    cfg_write(4, 16'hFF9C);
    send_vec(16'd1, 16'd2, 16'd3, 16'd4, acc_cyc);
    wait_result("t2a", res);
    check("t2 relu", res, 16'd0);
    wait_idle("t2a");
    cfg_write(4, 16'd5);
    send_vec(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, acc_cyc);
    wait_result("t2b", res);
    check("t2 neg x", res, 16'd1);
    wait_idle("t2b");

    // 3: saturation, values pass bit-exact
    set_wb(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0);
    check("t3 nx_w", nx_w, 64'h7FFF_7FFF_7FFF_7FFF);
    send_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, acc_cyc);
    check("t3 nx_x", nx_x, 64'h7FFF_7FFF_7FFF_7FFF);
    wait_result("t3", res);
    check("t3 sat", res, 16'h7FFF);
    wait_idle("t3");

    // 4: backpressure, credit stops the 5th vector in ISSUE
    set_wb(16'd1, 16'd0, 16'd0, 16'd0, 16'd0);
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_vec(16'(k), 16'd0, 16'd0, 16'd0, acc_cyc);
    repeat (10) @(negedge clk);
    check("t4 stuck s_ready", s_ready, 0);
    check("t4 m_valid", m_valid, 1);
    check("t4 head", m_data, 16'd1);
    check("t4 busy", busy, 1);
    got = 0;
    fork
      send_vec(16'd6, 16'd0, 16'd0, 16'd0, acc_cyc);
      begin
        m_ready = 1'b1;
        n = 0;
        while (got < 6 && n < 400) begin
          if (m_valid) begin
            check($sformatf("t4 order %0d", got), m_data, 64'(got + 1));
            stamp[got] = n;
            got++;
          end
          @(negedge clk);
          n++;
        end
      end
    join
    check("t4 count", got, 6);
    check("t4 burst", stamp[3] - stamp[0], 3);
    repeat (5) @(negedge clk);
    check("t4 drained", m_valid, 0);
    check("t4 busy end", busy, 0);

    // 5: reset drops a partial vector and clears the bank
    send_sample(16'd9);
    send_sample(16'd9);
    check("t5 partial busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5 rst s_ready", s_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5 busy", busy, 0);
    check("t5 nx_w", nx_w, 64'h0);
    check("t5 nx_x", nx_x, 64'h0);
    cfg_write(0, 16'd1);
    send_vec(16'd7, 16'd0, 16'd0, 16'd0, acc_cyc);
    wait_result("t5", res);
    check("t5 result", res, 16'd7);
    extra = 0;
    repeat (20) begin
      if (m_valid) extra++;
      @(negedge clk);
    end
    check("t5 no stale", extra, 0);
    check("t5 busy end", busy, 0);

    // 6: config writes while busy are dropped with a one-cycle error pulse
    send_vec(16'd5, 16'd0, 16'd0, 16'd0, acc_cyc);
    cfg_write(0, 16'd3);
    check("t6 cfg_err", cfg_err, 1);
    check("t6 w kept", nx_w, 64'h1);
    @(negedge clk);
    check("t6 cfg_err pulse", cfg_err, 0);
    cfg_write(6, 16'h55);
    check("t6 oor busy no err", cfg_err, 0);
    wait_result("t6", res);
    check("t6 result", res, 16'd5);
    wait_idle("t6");
    cfg_write(0, 16'd3);
    check("t6 idle no err", cfg_err, 0);
    check("t6 w applied", nx_w, 64'h3);
    cfg_write(5, 16'h55);
    check("t6 oor idle no err", cfg_err, 0);
    check("t6 oor w", nx_w, 64'h3);
    check("t6 oor b", nx_b, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
